rom_download_ctrl: RTL and testbench

Sits between `hps_io`'s ioctl download port and the `crazy_climber` core. It turns the HPS ROM stream into registered, region-tagged write strobes on the core's `dn_*` port. It holds the core in reset for the whole download and a fixed settle period afterwards. It reports byte-count, additive checksum and size-error status for the OSD/LED.

---
 rtl/rom_dl_pkg.sv | 29 ++
 rtl/rom_download_ctrl_if.sv | 26 ++
 rtl/rom_region_decode.sv | 31 +++
 rtl/rom_download_ctrl.sv | 142 ++++++++++++++
 tb/tb_rom_download_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and default map for the ROM download controller
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_PROG = 2'd0,
        REG_GFX  = 2'd1,
        REG_SND  = 2'd2
    } region_t;

    localparam int          IOCTL_AW          = 25;
    localparam int          BYTE_CNT_W        = 17;
    localparam int          DEF_EXPECTED_SIZE = 40960;
    localparam int          DEF_SETTLE_CYCLES = 1024;
    localparam logic [15:0] DEF_GFX_BASE      = 16'h6000;
    localparam logic [15:0] DEF_SND_BASE      = 16'h8000;

    // Saturating increment so an oversized stream cannot wrap back to a "valid" count.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + BYTE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rom_download_ctrl_if.sv
// rtl/rom_download_ctrl_if.sv - ioctl download stream in, core dn_* write port out
interface rom_download_ctrl_if
    import rom_dl_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic                ioctl_download;
    logic                ioctl_wr;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_dout;

    logic [ADDR_W-1:0]   dn_addr;
    logic [7:0]          dn_data;
    logic                dn_wr;
    region_t             dn_region;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_region
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_region
    );
endinterface

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - combinational byte address to ROM region / in-range decode
module rom_region_decode
    import rom_dl_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] GFX_BASE = ADDR_W'(DEF_GFX_BASE),
    parameter logic [ADDR_W-1:0] SND_BASE = ADDR_W'(DEF_SND_BASE),
    parameter int                LIMIT    = DEF_EXPECTED_SIZE
)(
    input  logic [IOCTL_AW-1:0] i_addr,
    output region_t             o_region,
    output logic                o_in_range
);

    localparam logic [IOCTL_AW-1:0] GFX_FULL   = IOCTL_AW'(GFX_BASE);
    localparam logic [IOCTL_AW-1:0] SND_FULL   = IOCTL_AW'(SND_BASE);
    localparam logic [IOCTL_AW-1:0] LIMIT_FULL = IOCTL_AW'(LIMIT);

    // Full-width compares: high ioctl bits must not alias into the window.
    assign o_in_range = (i_addr < LIMIT_FULL);

    always_comb begin
        o_region = REG_SND;
        if (i_addr < GFX_FULL) begin
            o_region = REG_PROG;
        end else if (i_addr < SND_FULL) begin
            o_region = REG_GFX;
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// rtl/rom_download_ctrl.sv - ioctl ROM download to core write strobes, reset hold and stats
module rom_download_ctrl
    import rom_dl_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                EXPECTED_SIZE = DEF_EXPECTED_SIZE,
    parameter logic [ADDR_W-1:0] GFX_BASE      = ADDR_W'(DEF_GFX_BASE),
    parameter logic [ADDR_W-1:0] SND_BASE      = ADDR_W'(DEF_SND_BASE),
    parameter int                SETTLE_CYCLES = DEF_SETTLE_CYCLES
)(
    input  logic                  clk_sys,
    input  logic                  reset_n,
    rom_download_ctrl_if.slave    bus,
    output logic                  core_reset,
    output logic                  rom_ok,
    output logic                  size_err,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic [7:0]            checksum
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                r_state;
    logic                  r_dl_q;
    logic [CNT_W-1:0]      r_settle_cnt;
    logic                  r_ovf;
    logic                  r_core_reset;
    logic                  r_rom_ok;
    logic                  r_size_err;
    logic [BYTE_CNT_W-1:0] r_byte_count;
    logic [7:0]            r_checksum;
    logic                  r_dn_wr;
    logic [ADDR_W-1:0]     r_dn_addr;
    logic [7:0]            r_dn_data;
    region_t               r_dn_region;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_in_range;
    region_t               w_region;
    logic                  w_accept;
    logic                  w_take;
    logic [BYTE_CNT_W-1:0] w_count_nxt;
    logic [7:0]            w_sum_nxt;
    logic                  w_ovf_nxt;
    logic                  w_bad;

    rom_region_decode #(
        .ADDR_W   (ADDR_W),
        .GFX_BASE (GFX_BASE),
        .SND_BASE (SND_BASE),
        .LIMIT    (EXPECTED_SIZE)
    ) u_decode (
        .i_addr     (bus.ioctl_addr),
        .o_region   (w_region),
        .o_in_range (w_in_range)
    );

    assign w_rise = bus.ioctl_download & ~r_dl_q;
    assign w_fall = ~bus.ioctl_download & r_dl_q;

    assign w_accept = (r_state == ST_LOAD) & bus.ioctl_wr;
    assign w_take   = w_accept & w_in_range;

    // Next-cycle stats, so the strobe coincident with the falling edge is included in the verdict.
    assign w_count_nxt = w_take ? sat_inc(r_byte_count) : r_byte_count;
    assign w_sum_nxt   = r_checksum + (w_take ? bus.ioctl_dout : 8'd0);
    assign w_ovf_nxt   = r_ovf | (w_accept & ~w_in_range);
    assign w_bad       = (w_count_nxt != BYTE_CNT_W'(EXPECTED_SIZE)) | w_ovf_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_dl_q       <= 1'b0;
            r_settle_cnt <= '0;
            r_ovf        <= 1'b0;
            r_core_reset <= 1'b1;
            r_rom_ok     <= 1'b0;
            r_size_err   <= 1'b0;
            r_byte_count <= '0;
            r_checksum   <= 8'd0;
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= 8'd0;
            r_dn_region  <= REG_PROG;
        end else begin
            r_dl_q  <= bus.ioctl_download;
            r_dn_wr <= 1'b0;

            if (w_rise && (r_state != ST_LOAD)) begin
                r_state      <= ST_LOAD;
                r_core_reset <= 1'b1;
                r_ovf        <= 1'b0;
                r_rom_ok     <= 1'b0;
                r_size_err   <= 1'b0;
                r_byte_count <= '0;
                r_checksum   <= 8'd0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_take) begin
                            r_dn_wr     <= 1'b1;
                            r_dn_addr   <= bus.ioctl_addr[ADDR_W-1:0];
                            r_dn_data   <= bus.ioctl_dout;
                            r_dn_region <= w_region;
                        end
                        r_byte_count <= w_count_nxt;
                        r_checksum   <= w_sum_nxt;
                        r_ovf        <= w_ovf_nxt;
                        if (w_fall) begin
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                            r_size_err   <= w_bad;
                            r_rom_ok     <= ~w_bad;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            r_state      <= ST_READY;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.dn_wr     = r_dn_wr;
    assign bus.dn_addr   = r_dn_addr;
    assign bus.dn_data   = r_dn_data;
    assign bus.dn_region = r_dn_region;
    assign core_reset    = r_core_reset;
    assign rom_ok        = r_rom_ok;
    assign size_err      = r_size_err;
    assign byte_count    = r_byte_count;
    assign checksum      = r_checksum;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// tb/tb_rom_download_ctrl.sv - directed self-checking bench for rom_download_ctrl
module tb_rom_download_ctrl;
    import rom_dl_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        core_reset;
    logic        rom_ok;
    logic        size_err;
    logic [16:0] byte_count;
    logic [7:0]  checksum;

    rom_download_ctrl_if #(.ADDR_W(16)) bus ();

    rom_download_ctrl #(
        .ADDR_W        (16),
        .EXPECTED_SIZE (40960),
        .GFX_BASE      (16'h6000),
        .SND_BASE      (16'h8000),
        .SETTLE_CYCLES (1024)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .rom_ok     (rom_ok),
        .size_err   (size_err),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_region(input logic [24:0] a);
        if (a < 25'h6000) return 2'd0;
        if (a < 25'h8000) return 2'd1;
        return 2'd2;
    endfunction

    // Write-port monitor: every dn_wr must follow exactly one accepted, in-range strobe.
    logic        exp_load = 1'b0;
    logic        p_wr = 1'b0;
    logic        p_load = 1'b0;
    logic [24:0] p_addr = '0;
    logic [7:0]  p_dout = '0;
    logic        m_exp_wr;
    int          mon_pulses = 0;
    int          mon_errs = 0;
    logic        cr_low_seen = 1'b0;
    logic [1:0]  reg_5fff = 2'd3, reg_6000 = 2'd3, reg_7fff = 2'd3, reg_8000 = 2'd3, reg_9fff = 2'd3;

    always @(negedge clk_sys) begin
        m_exp_wr = p_wr && p_load && (p_addr < 25'd40960);
        if (bus.dn_wr !== m_exp_wr) begin
            mon_errs++;
        end else if (m_exp_wr) begin
            if (bus.dn_addr !== p_addr[15:0] || bus.dn_data !== p_dout ||
                bus.dn_region !== exp_region(p_addr)) mon_errs++;
        end
        if (bus.dn_wr === 1'b1) begin
            mon_pulses++;
            case (bus.dn_addr)
                16'h5FFF: reg_5fff = bus.dn_region;
                16'h6000: reg_6000 = bus.dn_region;
                16'h7FFF: reg_7fff = bus.dn_region;
                16'h8000: reg_8000 = bus.dn_region;
                16'h9FFF: reg_9fff = bus.dn_region;
                default: ;
            endcase
        end
        if (core_reset === 1'b0) cr_low_seen = 1'b1;
        p_wr   = bus.ioctl_wr;
        p_load = exp_load;
        p_addr = bus.ioctl_addr;
        p_dout = bus.ioctl_dout;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl();
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr       = 1'b0;
        tick();
        exp_load = 1'b1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
    endtask

    task automatic end_dl();
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        exp_load = 1'b0;
    endtask

    task automatic end_dl_strobe(input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = a;
        bus.ioctl_dout     = d;
        bus.ioctl_download = 1'b0;
        tick();
        exp_load    = 1'b0;
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 1;
        while (core_reset !== 1'b0 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int   n;
        int   pb;
        logic [7:0] sum;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #10;
        check_eq("rst_core_reset", core_reset, 1);
        check_eq("rst_dn_wr", bus.dn_wr, 0);
        check_eq("rst_dn_addr", bus.dn_addr, 0);
        check_eq("rst_rom_ok", rom_ok, 0);
        check_eq("rst_size_err", size_err, 0);
        check_eq("rst_byte_count", byte_count, 0);
        check_eq("rst_checksum", checksum, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // IDLE strobes are ignored
        pb = mon_pulses;
        for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'hA5);
        bus.ioctl_wr = 1'b0;
        tick();
        check_eq("idle_no_dn_wr", mon_pulses - pb, 0);
        check_eq("idle_byte_count", byte_count, 0);

        // Full load
        pb = mon_pulses;
        start_dl();
        check_eq("full_core_reset_load", core_reset, 1);
        wr_byte(25'd0, 8'd0);
        check_eq("full_first_dn_wr", bus.dn_wr, 1);
        for (int a = 1; a < 40960; a++) wr_byte(25'(a), 8'(a));
        end_dl();
        check_eq("full_byte_count", byte_count, 40960);
        check_eq("full_checksum", checksum, 8'h00);
        check_eq("full_rom_ok", rom_ok, 1);
        check_eq("full_size_err", size_err, 0);
        check_eq("full_core_reset_settle", core_reset, 1);
        wait_release(n);
        check_eq("full_release_cycles", n, 1025);
        check_eq("full_dn_pulses", mon_pulses - pb, 40960);
        check_eq("region_5fff", reg_5fff, 0);
        check_eq("region_6000", reg_6000, 1);
        check_eq("region_7fff", reg_7fff, 1);
        check_eq("region_8000", reg_8000, 2);
        check_eq("region_9fff", reg_9fff, 2);
        check_eq("full_mon_errs", mon_errs, 0);
        check_eq("ready_rom_ok_held", rom_ok, 1);

        // Short load from READY, last strobe on the falling-edge cycle
        check_eq("short_core_reset_ready", core_reset, 0);
        start_dl();
        check_eq("short_core_reset_rise", core_reset, 1);
        check_eq("short_cleared_count", byte_count, 0);
        sum = 8'd0;
        for (int a = 0; a < 99; a++) begin
            wr_byte(25'(a), 8'(a * 3));
            sum = sum + 8'(a * 3);
        end
        end_dl_strobe(25'd99, 8'(99 * 3));
        sum = sum + 8'(99 * 3);
        check_eq("short_byte_count", byte_count, 100);
        check_eq("short_checksum", checksum, sum);
        check_eq("short_size_err", size_err, 1);
        check_eq("short_rom_ok", rom_ok, 0);
        wait_release(n);
        check_eq("short_release_cycles", n, 1025);

        // READY strobes are ignored
        pb = mon_pulses;
        for (int i = 0; i < 3; i++) wr_byte(25'(i + 10), 8'h3C);
        bus.ioctl_wr = 1'b0;
        tick();
        check_eq("ready_no_dn_wr", mon_pulses - pb, 0);
        check_eq("ready_byte_count", byte_count, 100);
        check_eq("ready_core_reset", core_reset, 0);

        // Overflow: full set plus out-of-range writes
        pb = mon_pulses;
        start_dl();
        cr_low_seen = 1'b0;
        for (int a = 0; a < 40960; a++) wr_byte(25'(a), 8'(a));
        wr_byte(25'h000A000, 8'hFF);
        wr_byte(25'h1000000, 8'h77);
        end_dl();
        check_eq("ovf_byte_count", byte_count, 40960);
        check_eq("ovf_checksum", checksum, 8'h00);
        check_eq("ovf_size_err", size_err, 1);
        check_eq("ovf_rom_ok", rom_ok, 0);
        check_eq("ovf_dn_pulses", mon_pulses - pb, 40960);

        // Restart during SETTLE with the counter at 500
        for (int i = 0; i < 523; i++) tick();
        start_dl();
        check_eq("restart_byte_count", byte_count, 0);
        check_eq("restart_checksum", checksum, 0);
        check_eq("restart_rom_ok", rom_ok, 0);
        check_eq("restart_size_err", size_err, 0);
        check_eq("restart_core_reset", core_reset, 1);
        for (int a = 0; a < 2000; a++) wr_byte(25'(a), 8'(a));
        bus.ioctl_wr = 1'b0;
        check_eq("restart_count_2000", byte_count, 2000);
        check_eq("restart_core_reset_never_low", cr_low_seen, 0);
        tick();

        // Async reset mid-download, download held high
        #2 reset_n = 1'b0;
        exp_load = 1'b0;
        #1;
        check_eq("arst_core_reset", core_reset, 1);
        check_eq("arst_byte_count", byte_count, 0);
        check_eq("arst_checksum", checksum, 0);
        check_eq("arst_dn_wr", bus.dn_wr, 0);
        check_eq("arst_dn_addr", bus.dn_addr, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        exp_load = 1'b1;
        check_eq("arst_relaunch_count", byte_count, 0);
        for (int a = 0; a < 10; a++) wr_byte(25'(a), 8'h11);
        check_eq("arst_byte_count_10", byte_count, 10);
        check_eq("arst_checksum_10", checksum, 8'hAA);
        end_dl();
        check_eq("arst_size_err", size_err, 1);
        check_eq("arst_rom_ok", rom_ok, 0);
        check_eq("final_mon_errs", mon_errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
